// File: rtl/compare_pipe.sv
// Two-stage pipelined compare unit: integer EQ/NE/LT/GE/LTU/GEU and single-precision FEQ/FLT/FLE.
// Stage 1 holds the subtract and float classification, stage 2 holds result/nv behind a valid/ready handshake.
module compare_pipe #(
   parameter int XLEN = 64,
   parameter int FLEN = 32,
   parameter int EXPW = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            result,
   output logic            nv,
   output logic            nv_sticky,
   input  logic            flags_clr
);

   localparam int MANW = FLEN - 1 - EXPW;
   localparam logic [FLEN-1:0] CANON_NAN = {1'b0, {EXPW{1'b1}}, 1'b1, {(MANW-1){1'b0}}};

   typedef enum logic [3:0] {
      OP_EQ  = 4'd0,
      OP_NE  = 4'd1,
      OP_LT  = 4'd2,
      OP_GE  = 4'd3,
      OP_LTU = 4'd4,
      OP_GEU = 4'd5,
      OP_FEQ = 4'd6,
      OP_FLT = 4'd7,
      OP_FLE = 4'd8
   } op_e;

   typedef struct packed {
      logic nan;
      logic snan;
      logic zero;
      logic sign;
   } fclass_t;

   function automatic fclass_t classify(input logic [FLEN-1:0] f);
      fclass_t c;
      c.nan  = (&f[FLEN-2 -: EXPW]) && (|f[MANW-1:0]);
      c.snan = c.nan && !f[MANW-1];
      c.zero = ~|f[FLEN-2:0];
      c.sign = f[FLEN-1];
      return c;
   endfunction

   // Upper bits that are not all ones mean the operand is not a properly boxed single.
   logic a_boxed, b_boxed;
   if (XLEN > FLEN) begin : g_box
      assign a_boxed = &a[XLEN-1:FLEN];
      assign b_boxed = &b[XLEN-1:FLEN];
   end else begin : g_nobox
      assign a_boxed = 1'b1;
      assign b_boxed = 1'b1;
   end

   logic            s1_valid_q, s1_valid_d;
   logic [3:0]      op_q, op_d;
   logic [XLEN:0]   diff_q, diff_d;
   logic            a_sign_q, a_sign_d, b_sign_q, b_sign_d;
   logic [FLEN-2:0] fa_mag_q, fa_mag_d, fb_mag_q, fb_mag_d;
   fclass_t         fa_cls_q, fa_cls_d, fb_cls_q, fb_cls_d;

   logic            s2_valid_q, s2_valid_d;
   logic            result_q, result_d;
   logic            nv_q, nv_d;
   logic            nv_sticky_q, nv_sticky_d;

   logic            s1_adv, s2_adv;
   logic [FLEN-1:0] fa, fb;
   logic            int_eq, int_lt, int_ltu;
   logic            any_nan, any_snan, both_zero, f_eq, f_lt;
   logic            cmp_result, cmp_nv;

   // Stage-2 outcome from the registered stage-1 fields.
   always_comb begin
      int_eq    = (diff_q[XLEN-1:0] == '0);
      int_ltu   = diff_q[XLEN];
      int_lt    = (a_sign_q != b_sign_q) ? a_sign_q : diff_q[XLEN-1];
      any_nan   = fa_cls_q.nan  || fb_cls_q.nan;
      any_snan  = fa_cls_q.snan || fb_cls_q.snan;
      both_zero = fa_cls_q.zero && fb_cls_q.zero;
      f_eq      = both_zero || ((fa_cls_q.sign == fb_cls_q.sign) && (fa_mag_q == fb_mag_q));
      if (fa_cls_q.sign != fb_cls_q.sign) begin
         f_lt = fa_cls_q.sign && !both_zero;
      end else if (!fa_cls_q.sign) begin
         f_lt = fa_mag_q < fb_mag_q;
      end else begin
         f_lt = fa_mag_q > fb_mag_q;
      end
      cmp_result = 1'b0;
      cmp_nv     = 1'b0;
      case (op_q)
         OP_EQ:  cmp_result = int_eq;
         OP_NE:  cmp_result = !int_eq;
         OP_LT:  cmp_result = int_lt;
         OP_GE:  cmp_result = !int_lt;
         OP_LTU: cmp_result = int_ltu;
         OP_GEU: cmp_result = !int_ltu;
         OP_FEQ: begin
            cmp_result = !any_nan && f_eq;
            cmp_nv     = any_snan;
         end
         OP_FLT: begin
            cmp_result = !any_nan && f_lt;
            cmp_nv     = any_nan;
         end
         OP_FLE: begin
            cmp_result = !any_nan && (f_lt || f_eq);
            cmp_nv     = any_nan;
         end
         default: begin
            cmp_result = 1'b0;
            cmp_nv     = 1'b0;
         end
      endcase
   end

   always_comb begin
      fa = a_boxed ? a[FLEN-1:0] : CANON_NAN;
      fb = b_boxed ? b[FLEN-1:0] : CANON_NAN;

      s2_adv = !s2_valid_q || out_ready;
      s1_adv = !s1_valid_q || s2_adv;

      s1_valid_d = s1_valid_q;
      op_d       = op_q;
      diff_d     = diff_q;
      a_sign_d   = a_sign_q;
      b_sign_d   = b_sign_q;
      fa_mag_d   = fa_mag_q;
      fb_mag_d   = fb_mag_q;
      fa_cls_d   = fa_cls_q;
      fb_cls_d   = fb_cls_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
      end
      if (s1_adv && in_valid) begin
         op_d     = op;
         diff_d   = {1'b0, a} - {1'b0, b};
         a_sign_d = a[XLEN-1];
         b_sign_d = b[XLEN-1];
         fa_mag_d = fa[FLEN-2:0];
         fb_mag_d = fb[FLEN-2:0];
         fa_cls_d = classify(fa);
         fb_cls_d = classify(fb);
      end

      s2_valid_d = s2_valid_q;
      result_d   = result_q;
      nv_d       = nv_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            result_d = cmp_result;
            nv_d     = cmp_nv;
         end
      end

      // A flagged result leaving this cycle beats a simultaneous clear.
      nv_sticky_d = nv_sticky_q;
      if (s2_valid_q && out_ready && nv_q) begin
         nv_sticky_d = 1'b1;
      end else if (flags_clr) begin
         nv_sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         op_q        <= '0;
         diff_q      <= '0;
         a_sign_q    <= 1'b0;
         b_sign_q    <= 1'b0;
         fa_mag_q    <= '0;
         fb_mag_q    <= '0;
         fa_cls_q    <= '0;
         fb_cls_q    <= '0;
         s2_valid_q  <= 1'b0;
         result_q    <= 1'b0;
         nv_q        <= 1'b0;
         nv_sticky_q <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         op_q        <= op_d;
         diff_q      <= diff_d;
         a_sign_q    <= a_sign_d;
         b_sign_q    <= b_sign_d;
         fa_mag_q    <= fa_mag_d;
         fb_mag_q    <= fb_mag_d;
         fa_cls_q    <= fa_cls_d;
         fb_cls_q    <= fb_cls_d;
         s2_valid_q  <= s2_valid_d;
         result_q    <= result_d;
         nv_q        <= nv_d;
         nv_sticky_q <= nv_sticky_d;
      end
   end

   assign in_ready  = s1_adv;
   assign out_valid = s2_valid_q;
   assign result    = result_q;
   assign nv        = nv_q;
   assign nv_sticky = nv_sticky_q;

endmodule

// File: tb/tb_compare_pipe.sv
// Self-checking bench for compare_pipe: a value-level reference model (real-number float compare,
// signed/unsigned integer compare) plus an in-order queue of expected results checked every cycle.
module tb_compare_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [63:0] a, b;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        result, nv, nv_sticky;
   logic        flags_clr = 1'b0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ready_mode = 0;
   int clr_mode = 0;
   logic model_ok = 1'b0;
   logic sticky_m = 1'b0;
   logic [63:0] last_operand = 64'h0;

   typedef struct {
      logic res;
      logic nv;
      int   tag;
   } exp_t;
   exp_t exp_q[$];

   localparam logic [63:0] BOX  = 64'hFFFF_FFFF_0000_0000;
   localparam logic [63:0] ONE  = BOX | 64'h3F80_0000;
   localparam logic [63:0] QNAN = BOX | 64'h7FC0_0000;
   localparam logic [63:0] SNAN = BOX | 64'h7F80_0001;

   compare_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .nv        (nv),
      .nv_sticky (nv_sticky),
      .flags_clr (flags_clr)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic logic [31:0] unbox(input logic [63:0] x);
      return (&x[63:32]) ? x[31:0] : 32'h7FC0_0000;
   endfunction

   function automatic logic is_nan(input logic [31:0] f);
      return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
   endfunction

   function automatic real fval(input logic [31:0] f);
      int  e;
      real mag;
      e = int'(f[30:23]);
      if (e == 0) mag = real'(int'(f[22:0])) * (2.0 ** (-149));
      else        mag = (real'(int'(f[22:0])) + 8388608.0) * (2.0 ** (e - 150));
      return f[31] ? -mag : mag;
   endfunction

   // Returns {result, nv} for one operation.
   function automatic logic [1:0] model_op(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
      logic [31:0] fx, fy;
      logic        anynan, anysnan;
      real         vx, vy;
      fx      = unbox(x);
      fy      = unbox(y);
      anynan  = is_nan(fx) || is_nan(fy);
      anysnan = (is_nan(fx) && !fx[22]) || (is_nan(fy) && !fy[22]);
      vx      = fval(fx);
      vy      = fval(fy);
      case (o)
         4'd0:    return {x == y, 1'b0};
         4'd1:    return {x != y, 1'b0};
         4'd2:    return {$signed(x) < $signed(y), 1'b0};
         4'd3:    return {$signed(x) >= $signed(y), 1'b0};
         4'd4:    return {x < y, 1'b0};
         4'd5:    return {x >= y, 1'b0};
         4'd6:    return anynan ? {1'b0, anysnan} : {vx == vy, 1'b0};
         4'd7:    return anynan ? 2'b01 : {vx < vy, 1'b0};
         4'd8:    return anynan ? 2'b01 : {vx <= vy, 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [63:0] rand_operand();
      logic [31:0] specials [10];
      logic [7:0]  s;
      logic [63:0] r;
      specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
                   32'h7F80_0001, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0001, 32'h7FBF_FFFF};
      s = 8'($urandom);
      case ($urandom % 8)
         0:       r = {$urandom, $urandom};
         1:       r = {{56{s[7]}}, s};
         2:       r = BOX | {32'h0, $urandom};
         3:       r = BOX | {32'h0, specials[$urandom % 10]};
         4:       r = {32'h0, $urandom};
         5:       r = (s[1:0] == 2'd0) ? 64'h8000_0000_0000_0000 :
                      (s[1:0] == 2'd1) ? 64'h7FFF_FFFF_FFFF_FFFF :
                      (s[1:0] == 2'd2) ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF;
         6:       r = BOX | {32'h0, 32'h3F80_0000 + ($urandom % 4)} | {32'h0, s[0], 31'h0};
         default: r = last_operand;
      endcase
      last_operand = r;
      return r;
   endfunction

   // Output-side drivers: 0 = forced low/high default, 1 = forced, 2 = random.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = ($urandom % 4) != 0;
      endcase
      case (clr_mode)
         0:       flags_clr = 1'b0;
         1:       flags_clr = 1'b1;
         default: flags_clr = ($urandom % 8) == 0;
      endcase
   end

   // Scoreboard: outputs are compared against the model state, then the model is advanced
   // to what the next rising edge will produce. An item captured at edge T is visible after T+1.
   logic exp_ov, exp_ir, set_nv;
   logic [1:0] mres;
   exp_t item;
   always @(negedge clk) begin
      exp_ov = (exp_q.size() > 0) && (exp_q[0].tag < cyc);
      exp_ir = !((exp_q.size() == 2) && !out_ready);
      if (model_ok) begin
         checkOutput("in_ready", in_ready, exp_ir);
         checkOutput("out_valid", out_valid, exp_ov);
         if (exp_ov) begin
            checkOutput("result", result, exp_q[0].res);
            checkOutput("nv", nv, exp_q[0].nv);
         end
         checkOutput("nv_sticky", nv_sticky, sticky_m);
      end
      if (reset) begin
         exp_q.delete();
         sticky_m = 1'b0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         set_nv = 1'b0;
         if (exp_ov && out_ready) begin
            set_nv = exp_q[0].nv;
            void'(exp_q.pop_front());
         end
         if (set_nv) sticky_m = 1'b1;
         else if (flags_clr) sticky_m = 1'b0;
         if (in_valid && exp_ir) begin
            mres     = model_op(op, a, b);
            item.res = mres[1];
            item.nv  = mres[0];
            item.tag = cyc + 1;
            exp_q.push_back(item);
         end
      end
      cyc++;
   end

   task automatic applyStimulus(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
      int n = 0;
      in_valid = 1'b1;
      op = o;
      a = x;
      b = y;
      @(negedge clk);
      while (!in_ready && n < 1000) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) checkOutput("accept_timeout", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         n++;
         @(posedge clk);
      end
      #1;
      if (exp_q.size() != 0) checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [63:0] x, y;
      int          sweep_ops [5];
      sweep_ops = '{0, 2, 3, 4, 5};
      reset = 1'b1;
      in_valid = 1'b0;
      op = 4'd0;
      a = 64'h0;
      b = 64'h0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      @(negedge clk);
      checkOutput("reset_in_ready", in_ready, 1'b1);
      checkOutput("reset_out_valid", out_valid, 1'b0);
      checkOutput("reset_result", result, 1'b0);
      checkOutput("reset_nv", nv, 1'b0);
      checkOutput("reset_sticky", nv_sticky, 1'b0);
      @(posedge clk);
      #1;

      // Hand-computed values that pin the reference model.
      checkOutput("model_lt_min", model_op(4'd2, 64'h8000_0000_0000_0000, 64'd1), 2'b10);
      checkOutput("model_ltu_min", model_op(4'd4, 64'h8000_0000_0000_0000, 64'd1), 2'b00);
      checkOutput("model_ge_m5", model_op(4'd3, -64'sd5, -64'sd5), 2'b10);
      checkOutput("model_feq_zeros", model_op(4'd6, BOX, BOX | 64'h8000_0000), 2'b10);
      checkOutput("model_flt_m1_1", model_op(4'd7, BOX | 64'hBF80_0000, ONE), 2'b10);
      checkOutput("model_fle_qnan", model_op(4'd8, QNAN, ONE), 2'b01);
      checkOutput("model_feq_snan", model_op(4'd6, SNAN, ONE), 2'b01);
      checkOutput("model_feq_qnan", model_op(4'd6, QNAN, QNAN), 2'b00);
      checkOutput("model_unboxed", model_op(4'd6, 64'h0000_0000_3F80_0000, ONE), 2'b00);
      checkOutput("model_boxed", model_op(4'd6, ONE, ONE), 2'b10);
      checkOutput("model_reserved", model_op(4'd9, ONE, ONE), 2'b00);

      // Latency: captured at one edge, visible after the next.
      applyStimulus(4'd2, 64'h8000_0000_0000_0000, 64'd1);
      @(negedge clk);
      checkOutput("latency_early", out_valid, 1'b0);
      @(negedge clk);
      checkOutput("latency_valid", out_valid, 1'b1);
      checkOutput("latency_result", result, 1'b1);
      @(posedge clk);
      #1;

      applyStimulus(4'd4, 64'h8000_0000_0000_0000, 64'd1);
      applyStimulus(4'd3, -64'sd5, -64'sd5);
      applyStimulus(4'd6, BOX, BOX | 64'h8000_0000);
      applyStimulus(4'd7, BOX | 64'hBF80_0000, ONE);
      applyStimulus(4'd8, QNAN, ONE);
      applyStimulus(4'd6, SNAN, ONE);
      applyStimulus(4'd6, QNAN, QNAN);
      applyStimulus(4'd6, 64'h0000_0000_3F80_0000, ONE);
      applyStimulus(4'd6, ONE, ONE);
      applyStimulus(4'd12, ONE, ONE);
      drain();

      // Sign-extended 8-bit sweep, streamed back-to-back.
      for (int i = 0; i < 18; i++) begin
         for (int j = 0; j < 18; j++) begin
            for (int k = 0; k < 5; k++) begin
               x = 64'(-128 + 15 * i);
               y = 64'(-128 + 15 * j);
               applyStimulus(4'(sweep_ops[k]), x, y);
            end
         end
      end
      for (int i = -2; i <= 2; i++) begin
         for (int j = -2; j <= 2; j++) begin
            for (int k = 0; k < 6; k++) applyStimulus(4'(k), 64'(i), 64'(j));
         end
      end
      drain();

      // Backpressure: two ops fill the pipe, the third waits for release.
      ready_mode = 1;
      idle(2);
      fork
         begin
            applyStimulus(4'd2, 64'd1, 64'd2);
            applyStimulus(4'd2, 64'd2, 64'd1);
            applyStimulus(4'd0, 64'd3, 64'd3);
         end
         begin
            repeat (6) @(negedge clk);
            checkOutput("bp_in_ready_low", in_ready, 1'b0);
            checkOutput("bp_out_valid", out_valid, 1'b1);
            checkOutput("bp_result_frozen", result, 1'b1);
            @(posedge clk);
            #1;
            ready_mode = 0;
         end
      join
      drain();

      // Sticky flag: set by a transfer, cleared alone, set wins over a simultaneous clear.
      applyStimulus(4'd8, QNAN, ONE);
      drain();
      idle(2);
      @(negedge clk);
      checkOutput("sticky_after_nv", nv_sticky, 1'b1);
      @(posedge clk);
      #1;
      ready_mode = 1;
      idle(2);
      applyStimulus(4'd7, SNAN, ONE);
      clr_mode = 1;
      idle(3);
      @(negedge clk);
      checkOutput("sticky_clr_alone", nv_sticky, 1'b0);
      @(posedge clk);
      #1;
      ready_mode = 0;
      drain();
      clr_mode = 0;
      idle(2);

      // Reset with two operations in flight.
      applyStimulus(4'd0, 64'd7, 64'd7);
      applyStimulus(4'd8, QNAN, ONE);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset_midop_out_valid", out_valid, 1'b0);
      @(posedge clk);
      #1;
      idle(4);

      // Randomized traffic with random backpressure and clears.
      ready_mode = 2;
      clr_mode = 2;
      for (int i = 0; i < 2500; i++) begin
         x = rand_operand();
         y = (($urandom % 5) == 0) ? x : rand_operand();
         applyStimulus(4'($urandom % 16), x, y);
         if (($urandom % 6) == 0) idle(1 + int'($urandom % 3));
      end
      ready_mode = 0;
      clr_mode = 0;
      drain();
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
